// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Sequencer for a WIDTH-bit down-counter. A load value and repeat count are
//   accepted over a valid/ready handshake. A start request then runs one or
//   more countdown passes, which can be paused, aborted or reset.
//
// Ports
//   clk        in   1         system clock, all logic on posedge
//   rs         in   1         synchronous active-high reset
//   cfg_valid  in   1         cfg_load/cfg_reps valid
//   cfg_ready  out  1         configuration accepted (IDLE or ARMED)
//   cfg_load   in   WIDTH     start value of each countdown pass
//   cfg_reps   in   REPEAT_W  extra passes after the first (0 = single pass)
//   start      in   1         launch armed sequence (level, sampled per edge)
//   pause      in   1         freeze count while high
//   abort      in   1         cancel sequence, return to IDLE
//   q          out  WIDTH     current count value
//   rep_left   out  REPEAT_W  passes remaining after the current one
//   busy       out  1         high in RUN or HOLD
//   tick       out  1         1-cycle pulse: a pass reached terminal count
//   done       out  1         1-cycle pulse: final pass complete
module countdown_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rs,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WIDTH-1:0]    cfg_load,
  input  logic [REPEAT_W-1:0] cfg_reps,
  input  logic                start,
  input  logic                pause,
  input  logic                abort,
  output logic [WIDTH-1:0]    q,
  output logic [REPEAT_W-1:0] rep_left,
  output logic                busy,
  output logic                tick,
  output logic                done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [WIDTH-1:0]    Q_ONE   = WIDTH'(1);
  localparam logic [REPEAT_W-1:0] REP_ONE = REPEAT_W'(1);

  logic [2:0]       state;
  logic [WIDTH-1:0] load_r;

  // Both outputs decode the registered state only, so they are glitch-free
  // and change on the same edge as the state itself.
  assign cfg_ready = (state == IDLE) || (state == ARMED);
  assign busy      = (state == RUN)  || (state == HOLD);

  always_ff @(posedge clk) begin
    if (rs) begin
      state    <= IDLE;
      q        <= '0;
      rep_left <= '0;
      load_r   <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Strobes are pulses: cleared every edge unless re-raised below.
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort has no effect here, so a configuration still lands.
          if (cfg_valid) begin
            load_r   <= cfg_load;
            q        <= cfg_load;
            rep_left <= cfg_reps;
            state    <= ARMED;
          end
        end
        ARMED: begin
          // A configuration on the same edge as start wins; start is dropped.
          if (abort) begin
            q        <= '0;
            rep_left <= '0;
            state    <= IDLE;
          end else if (cfg_valid) begin
            load_r   <= cfg_load;
            q        <= cfg_load;
            rep_left <= cfg_reps;
          end else if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            q        <= '0;
            rep_left <= '0;
            state    <= IDLE;
          end else if (pause) begin
            state <= HOLD;
          end else if (q != '0) begin
            q <= q - Q_ONE;
          end else if (rep_left != '0) begin
            tick     <= 1'b1;
            q        <= load_r;
            rep_left <= rep_left - REP_ONE;
          end else begin
            tick  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        HOLD: begin
          if (abort) begin
            q        <= '0;
            rep_left <= '0;
            state    <= IDLE;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        DONE: begin
          // q and rep_left are already zero here; re-clearing keeps abort and
          // normal exit identical.
          q        <= '0;
          rep_left <= '0;
          state    <= IDLE;
        end
        default: begin
          q        <= '0;
          rep_left <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
